ahb_sram_slave: RTL and testbench
=================================

# ahb_sram_slave

Word-addressed AHB slave memory that answers the bus master's NONSEQ/SEQ transfers with programmable wait states and an ERROR response for out-of-window addresses. It sits directly downstream of the bus master on the shared AHB bus. It serves both the master's read window at 0x1A00 and its write window at 0x1B00. In a single-slave system its `hready_o` drives the bus `hready` seen by the master and by this block's `hready_i`.

## Interface
- `BASE_ADDR`, default 'h1A00: byte address of word 0; must be 4-byte aligned.
- `DEPTH`, default 128: number of 32-bit words; window is BASE_ADDR .. BASE_ADDR+4*DEPTH-1.
- `WAIT_CYCLES`, default 0: number of `hready_o`-low cycles inserted in every OKAY data phase (0..15).
- `hclk_i` in 1: the single clock; all logic is on its rising edge.
- `irst_n` in 1: reset, synchronous, active-low.
- `hsel_i` in 1: slave select.
- `haddr_i` in 32: byte address of the address phase.
- `htrans_i` in 2: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- `hwrite_i` in 1: 1 = write, 0 = read.
- `hwdata_i` in 32: write data, valid in the write data phase.
- `hready_i` in 1: bus ready; the address phase is sampled only when it is high.
- `hrdata_o` out 32: read data.
- `hready_o` out 1: this slave's data-phase ready.
- `hresp_o` out 2: OKAY=00, ERROR=01.

## Operation
- **Accept:** an address phase is accepted on the edge where `hsel_i & htrans_i[1] & hready_i` is true. On acceptance, latch `hwrite_i` and the word index `(haddr_i-BASE_ADDR)>>2`.
- **IDLE/BUSY:** transfers with `htrans_i` = IDLE or BUSY, or with `hsel_i` low, are not accepted. They get a zero-wait OKAY: `hready_o`=1, `hresp_o`=00.
- **Address legality:** an address is legal when `haddr_i[1:0]==0` and `BASE_ADDR <= haddr_i < BASE_ADDR+4*DEPTH`. Use 33-bit compare so there is no wrap at 2^32.
- **States:**
  - ST_IDLE: no data phase; `hready_o`=1, OKAY.
  - ST_WAIT: `hready_o`=0, OKAY; `wait_cnt` decrements.
  - ST_LAST: final data-phase cycle; `hready_o`=1, OKAY.
  - ST_ERR1: `hready_o`=0, ERROR.
  - ST_ERR2: `hready_o`=1, ERROR.
- **Transitions out of ST_IDLE, ST_LAST or ST_ERR2** (the cycles where `hready_o`=1):
  - Accepted and illegal address → ST_ERR1.
  - Accepted, legal address, `WAIT_CYCLES`=0 → ST_LAST.
  - Accepted, legal address, `WAIT_CYCLES`>0 → ST_WAIT, with `wait_cnt` loaded with `WAIT_CYCLES-1`.
  - Otherwise → ST_IDLE.
- **Other transitions:** ST_WAIT → ST_LAST when `wait_cnt`=0. ST_ERR1 → ST_ERR2 always.
- **Write:** the memory word is written with `hwdata_i` at the end of the ST_LAST cycle when the latched `hwrite` is 1. An ERROR transfer never writes.
- **Read:** in ST_LAST with latched `hwrite`=0, `hrdata_o` = mem[latched index], read combinationally. In every other state `hrdata_o`=0.
- **Pipelining:** back-to-back transfers are supported. A new address phase is accepted in the same ST_LAST cycle that completes the previous data phase. A read issued directly after a write to the same word returns the new data, because the write commits before the read's data phase.
- **Reset:** memory contents are not reset and are undefined after power-up.

## Timing
- **Reset values:** `hready_o`=1, `hresp_o`=00, `hrdata_o`=0, state=ST_IDLE, `wait_cnt`=0.
- **Reset mid-transfer:** a synchronous reset asserted during a data phase aborts it. The next cycle shows the reset values, and a write in ST_LAST under reset is not committed.
- **OKAY latency:** with address phase in cycle T, the data phase occupies cycles T+1 .. T+1+WAIT_CYCLES. `hready_o` is low for exactly WAIT_CYCLES cycles, then high for one cycle.
- **ERROR:** always exactly 2 cycles, independent of WAIT_CYCLES: low/ERROR, then high/ERROR.
- **Sustained throughput:** one transfer per WAIT_CYCLES+1 cycles.
- **Inputs during waits:** `haddr_i`/`htrans_i` are ignored while `hready_i`=0; the master holds them.

## Structure
- **Shared package `ahb_pkg`:** HTRANS encodings, HRESP encodings, and the slave state encoding (3-bit). The `ahb_master` block reuses the same package.
- **Sub-module `ahb_slave_mem`:** DEPTH×32 register array with one synchronous write port and one combinational read port.
- **Top level:** holds the decode, the FSM and `wait_cnt`.

## Test plan
- **Reset values:** assert `irst_n`=0 for 2 cycles → `hready_o`=1, `hresp_o`=00, `hrdata_o`=0.
- **Zero-wait burst:** `WAIT_CYCLES`=0. Write NONSEQ+3×SEQ to 0x1B00..0x1B0C with data 0xA0..0xA3, then read the same addresses back-to-back → `hready_o` never low; read data 0xA0..0xA3, one word per cycle.
- **Wait states:** `WAIT_CYCLES`=2. Single read of 0x1A04 after writing 0x12345678 → `hready_o` low for exactly 2 cycles, then high with `hrdata_o`=0x12345678 and OKAY.
- **Out-of-window address:** access 0x1C00 → `hready_o`=0 with ERROR, then `hready_o`=1 with ERROR; a following read of 0x1C00's aliased words shows no memory change.
- **Misaligned address:** access 0x1A02 → 2-cycle ERROR.
- **Reset mid-write / IDLE and BUSY:** assert reset in ST_LAST of a write of 0xDEADBEEF to 0x1A10 → the old word is kept. Drive `htrans_i`=00 and 01 with `hsel_i`=1 → zero-wait OKAY and no state change.

Source files
------------

// File: rtl/ahb_pkg.sv
// AHB encodings and slave state codes shared by the slave and master blocks.
// Pure declarations: no logic, no latency, no flow control.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_LAST = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  // 33-bit window compare so a window near the top of the space cannot wrap
  function automatic logic addr_legal(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [32:0] win_end);
    return (addr[1:0] == 2'b00) &&
           ({1'b0, addr} >= {1'b0, base}) &&
           ({1'b0, addr} < win_end);
  endfunction

endpackage

// File: rtl/ahb_slave_mem.sv
// DEPTH x 32 register array: one synchronous write port, one combinational read port.
// Write lands on the clock edge; read data follows the read index in the same cycle.
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int IDX_W = 7
) (
  input  logic             hclk_i,
  input  logic             wr_vld,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_dat,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_dat
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge hclk_i) begin
    if (wr_vld) begin
      mem[wr_idx] <= wr_dat;
    end
  end

  assign rd_dat = mem[rd_idx];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB word SRAM slave: OKAY data phase of WAIT_CYCLES+1 cycles, 2-cycle ERROR outside the window.
// Stalls the bus by holding hready_o low during wait states and the first ERROR cycle.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1A00,
  parameter int          DEPTH       = 128,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        hclk_i,
  input  logic        irst_n,
  input  logic        hsel_i,
  input  logic [31:0] haddr_i,
  input  logic [1:0]  htrans_i,
  input  logic        hwrite_i,
  input  logic [31:0] hwdata_i,
  input  logic        hready_i,
  output logic [31:0] hrdata_o,
  output logic        hready_o,
  output logic [1:0]  hresp_o
);

  localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] WIN_END   = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);
  localparam int unsigned WAIT_LD   = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_LD);

  logic [2:0]       state, state_d;
  logic [3:0]       wait_cnt, wait_d;
  logic             hwrite_q;
  logic [IDX_W-1:0] idx_q;
  logic             take;
  logic             accept;
  logic             legal;
  logic [31:0]      offset;
  logic [31:0]      rd_dat;
  logic             unused_offset_bits;

  assign accept = hsel_i & htrans_i[1] & hready_i;
  assign legal  = addr_legal(haddr_i, BASE_ADDR, WIN_END);
  assign offset = haddr_i - BASE_ADDR;
  assign unused_offset_bits = ^{offset[31:IDX_W+2], offset[1:0]};

  always_comb begin
    state_d = state;
    wait_d  = wait_cnt;
    take    = 1'b0;
    case (state)
      ST_IDLE, ST_LAST, ST_ERR2: begin
        if (accept) begin
          take = 1'b1;
          if (!legal) begin
            state_d = ST_ERR1;
          end else if (WAIT_CYCLES == 0) begin
            state_d = ST_LAST;
          end else begin
            state_d = ST_WAIT;
            wait_d  = WAIT_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_d = ST_LAST;
        end else begin
          wait_d = wait_cnt - 4'd1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk_i) begin
    if (!irst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      hwrite_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_d;
      if (take) begin
        hwrite_q <= hwrite_i;
        idx_q    <= offset[IDX_W+1:2];
      end
    end
  end

  // Reset gates the commit so an aborted write leaves the old word intact
  ahb_slave_mem #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .hclk_i (hclk_i),
    .wr_vld (irst_n && (state == ST_LAST) && hwrite_q),
    .wr_idx (idx_q),
    .wr_dat (hwdata_i),
    .rd_idx (idx_q),
    .rd_dat (rd_dat)
  );

  assign hrdata_o = ((state == ST_LAST) && !hwrite_q) ? rd_dat : 32'h0;
  assign hready_o = !((state == ST_WAIT) || (state == ST_ERR1));
  assign hresp_o  = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: a zero-wait slave (u0) and a two-wait slave (u2) share the bus,
// each selected separately and each seeing its own hready_o as the bus hready.
module tb_ahb_sram_slave;

  logic        hclk;
  logic        irst_n;
  logic        hsel0, hsel2;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [31:0] rdata0, rdata2;
  logic        rdy0, rdy2;
  logic [1:0]  resp0, resp2;

  int vecs = 0;
  int errs = 0;

  ahb_sram_slave #(.BASE_ADDR(32'h1A00), .DEPTH(128), .WAIT_CYCLES(0)) u0 (
    .hclk_i(hclk), .irst_n(irst_n), .hsel_i(hsel0), .haddr_i(haddr),
    .htrans_i(htrans), .hwrite_i(hwrite), .hwdata_i(hwdata), .hready_i(rdy0),
    .hrdata_o(rdata0), .hready_o(rdy0), .hresp_o(resp0)
  );

  ahb_sram_slave #(.BASE_ADDR(32'h1A00), .DEPTH(128), .WAIT_CYCLES(2)) u2 (
    .hclk_i(hclk), .irst_n(irst_n), .hsel_i(hsel2), .haddr_i(haddr),
    .htrans_i(htrans), .hwrite_i(hwrite), .hwdata_i(hwdata), .hready_i(rdy2),
    .hrdata_o(rdata2), .hready_o(rdy2), .hresp_o(resp2)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic bus(input logic [31:0] a, input logic [1:0] t, input logic w);
    haddr  = a;
    htrans = t;
    hwrite = w;
  endtask

  initial begin
    irst_n = 1'b0;
    hsel0  = 1'b0;
    hsel2  = 1'b0;
    hwdata = 32'h0;
    bus(32'h0, 2'b00, 1'b0);

    // Reset values
    tick();
    tick();
    chk("rst_rdy0",  32'(rdy0),  32'h1);
    chk("rst_resp0", 32'(resp0), 32'h0);
    chk("rst_rdata0", rdata0,    32'h0);
    chk("rst_rdy2",  32'(rdy2),  32'h1);
    chk("rst_rdata2", rdata2,    32'h0);
    irst_n = 1'b1;

    // Zero-wait burst: write 0x1B00..0x1B0C then read them back-to-back
    hsel0 = 1'b1;
    bus(32'h1B00, 2'b10, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("burst_wr_rdy", 32'(rdy0), 32'h1);
      hwdata = 32'hA0 + 32'(i);
      if (i < 3) bus(32'h1B04 + 32'(4 * i), 2'b11, 1'b1);
      else       bus(32'h1B00, 2'b10, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("burst_rd_rdy", 32'(rdy0), 32'h1);
      chk("burst_rd_dat", rdata0, 32'hA0 + 32'(i));
      chk("burst_rd_resp", 32'(resp0), 32'h0);
      if (i < 3) bus(32'h1B04 + 32'(4 * i), 2'b11, 1'b0);
      else       bus(32'h0, 2'b00, 1'b0);
    end
    tick();
    chk("burst_end_rdata", rdata0, 32'h0);
    hsel0 = 1'b0;

    // Two wait states on u2: write 0x1A04 then read it back
    hsel2 = 1'b1;
    bus(32'h1A04, 2'b10, 1'b1);
    tick();
    bus(32'h0, 2'b00, 1'b0);
    hwdata = 32'h12345678;
    chk("ws_wr_w1", 32'(rdy2), 32'h0);
    tick();
    chk("ws_wr_w2", 32'(rdy2), 32'h0);
    tick();
    chk("ws_wr_last", 32'(rdy2), 32'h1);
    chk("ws_wr_resp", 32'(resp2), 32'h0);
    bus(32'h1A04, 2'b10, 1'b0);
    tick();
    bus(32'h0, 2'b00, 1'b0);
    chk("ws_rd_w1", 32'(rdy2), 32'h0);
    chk("ws_rd_w1_dat", rdata2, 32'h0);
    tick();
    chk("ws_rd_w2", 32'(rdy2), 32'h0);
    tick();
    chk("ws_rd_last", 32'(rdy2), 32'h1);
    chk("ws_rd_dat", rdata2, 32'h12345678);
    chk("ws_rd_resp", 32'(resp2), 32'h0);
    tick();
    chk("ws_idle_rdy", 32'(rdy2), 32'h1);
    hsel2 = 1'b0;

    // Out-of-window write to 0x1C00 must not disturb word 0 (0x1A00)
    hsel0 = 1'b1;
    bus(32'h1A00, 2'b10, 1'b1);
    tick();
    hwdata = 32'h5555AAAA;
    bus(32'h1C00, 2'b10, 1'b1);
    tick();
    hwdata = 32'hBAD0BAD0;
    bus(32'h0, 2'b00, 1'b0);
    chk("oow_err1_rdy", 32'(rdy0), 32'h0);
    chk("oow_err1_resp", 32'(resp0), 32'h1);
    tick();
    chk("oow_err2_rdy", 32'(rdy0), 32'h1);
    chk("oow_err2_resp", 32'(resp0), 32'h1);
    bus(32'h1A00, 2'b10, 1'b0);
    tick();
    chk("oow_alias_dat", rdata0, 32'h5555AAAA);
    chk("oow_alias_resp", 32'(resp0), 32'h0);

    // Misaligned read of 0x1A02
    bus(32'h1A02, 2'b10, 1'b0);
    tick();
    bus(32'h0, 2'b00, 1'b0);
    chk("mis_err1_rdy", 32'(rdy0), 32'h0);
    chk("mis_err1_resp", 32'(resp0), 32'h1);
    tick();
    chk("mis_err2_rdy", 32'(rdy0), 32'h1);
    chk("mis_err2_resp", 32'(resp0), 32'h1);
    tick();
    chk("mis_after_resp", 32'(resp0), 32'h0);

    // Reset during the last cycle of a write keeps the old word
    bus(32'h1A10, 2'b10, 1'b1);
    tick();
    hwdata = 32'h11110000;
    bus(32'h1A10, 2'b10, 1'b1);
    tick();
    hwdata = 32'hDEADBEEF;
    bus(32'h0, 2'b00, 1'b0);
    irst_n = 1'b0;
    tick();
    chk("midrst_rdy", 32'(rdy0), 32'h1);
    chk("midrst_resp", 32'(resp0), 32'h0);
    chk("midrst_rdata", rdata0, 32'h0);
    irst_n = 1'b1;
    bus(32'h1A10, 2'b10, 1'b0);
    tick();
    bus(32'h0, 2'b00, 1'b0);
    chk("midrst_keep", rdata0, 32'h11110000);

    // IDLE and BUSY with hsel high: zero-wait OKAY, no data phase
    tick();
    bus(32'h1A10, 2'b00, 1'b0);
    tick();
    chk("idle_rdy", 32'(rdy0), 32'h1);
    chk("idle_resp", 32'(resp0), 32'h0);
    chk("idle_rdata", rdata0, 32'h0);
    bus(32'h1A10, 2'b01, 1'b0);
    tick();
    chk("busy_rdy", 32'(rdy0), 32'h1);
    chk("busy_resp", 32'(resp0), 32'h0);
    chk("busy_rdata", rdata0, 32'h0);
    hsel0 = 1'b0;
    bus(32'h0, 2'b00, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
